// File: rtl/ultrasonic_echo_emulator.sv
// Behavioural stand-in for an HC-SR04-style ranging sensor: validates the trigger pulse width,
// waits a fixed burst delay, then returns an echo whose width in fpgaclk cycles encodes distance.
module ultrasonic_echo_emulator #(
    parameter int WIDTH        = 22,
    parameter int MIN_TRIG     = 500,
    parameter int BURST_CYCLES = 10000,
    parameter int MAX_ECHO     = 1900000,
    parameter int HOLDOFF      = 500
) (
    input  logic             fpgaclk,
    input  logic             reset,
    input  logic             triggerin,
    input  logic [WIDTH-1:0] echo_width,
    output logic             pulse,
    output logic             busy,
    output logic             short_trig,
    output logic             timeout,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TRIG    = 3'd1,
        BURST   = 3'd2,
        ECHO    = 3'd3,
        HOLD    = 3'd4
    } state_t;

    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);
    localparam logic [WIDTH-1:0] MIN_T      = WIDTH'(MIN_TRIG);
    localparam logic [WIDTH-1:0] BURST_LAST = WIDTH'(BURST_CYCLES - 1);
    localparam logic [WIDTH-1:0] MAX_W      = WIDTH'(MAX_ECHO);
    localparam logic [WIDTH-1:0] HOLD_LAST  = WIDTH'(HOLDOFF - 1);

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] width_q;
    logic             timeout_flag;
    logic             sync_1;
    logic             trig_s;
    logic             trig_d;
    logic             no_object;

    assign dbg_state = state;

    // A zero or out-of-range request behaves like a sensor that never sees an object.
    assign no_object = (echo_width == '0) || (echo_width > MAX_W);

    always_ff @(posedge fpgaclk or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b0;
            trig_s <= 1'b0;
            trig_d <= 1'b0;
        end else begin
            sync_1 <= triggerin;
            trig_s <= sync_1;
            trig_d <= trig_s;
        end
    end

    always_ff @(posedge fpgaclk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            width_q      <= '0;
            timeout_flag <= 1'b0;
            pulse        <= 1'b0;
            busy         <= 1'b0;
            short_trig   <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            short_trig <= 1'b0;
            timeout    <= 1'b0;
            case (state)
                IDLE: begin
                    // Only a rising edge counts, so a level held over from HOLD is ignored.
                    if (trig_s && !trig_d) begin
                        state <= TRIG;
                        cnt   <= ONE;
                        busy  <= 1'b1;
                    end
                end
                TRIG: begin
                    if (trig_s) begin
                        if (cnt < MIN_T) begin
                            cnt <= cnt + ONE;
                        end
                    end else if (cnt >= MIN_T) begin
                        width_q      <= no_object ? MAX_W : echo_width;
                        timeout_flag <= no_object;
                        cnt          <= '0;
                        state        <= BURST;
                    end else begin
                        short_trig <= 1'b1;
                        busy       <= 1'b0;
                        cnt        <= '0;
                        state      <= IDLE;
                    end
                end
                BURST: begin
                    if (cnt == BURST_LAST) begin
                        cnt   <= '0;
                        pulse <= 1'b1;
                        state <= ECHO;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                ECHO: begin
                    // width_q is never zero, so the echo lasts exactly width_q cycles.
                    if (cnt == width_q - ONE) begin
                        cnt     <= '0;
                        pulse   <= 1'b0;
                        timeout <= timeout_flag;
                        state   <= HOLD;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    pulse <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ultrasonic_echo_emulator.sv
// Bench for ultrasonic_echo_emulator: a driver issues triggers and queues the expected echo or
// short-trigger event; an independent monitor pops and compares whenever the DUT produces one.
module tb_ultrasonic_echo_emulator;

    localparam int WIDTH        = 22;
    localparam int MIN_TRIG     = 10;
    localparam int BURST_CYCLES = 20;
    localparam int MAX_ECHO     = 1000;
    localparam int HOLDOFF      = 8;
    localparam int EW           = 56;

    logic             clk = 1'b0;
    logic             reset;
    logic             triggerin;
    logic [WIDTH-1:0] echo_width;
    logic             pulse;
    logic             busy;
    logic             short_trig;
    logic             timeout;
    logic [2:0]       dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Expected event record: {is_short, timeout, width[21:0], event_edge[31:0]}
    logic [EW-1:0] exp_q[$];

    ultrasonic_echo_emulator #(
        .WIDTH(WIDTH), .MIN_TRIG(MIN_TRIG), .BURST_CYCLES(BURST_CYCLES),
        .MAX_ECHO(MAX_ECHO), .HOLDOFF(HOLDOFF)
    ) dut (
        .fpgaclk(clk), .reset(reset), .triggerin(triggerin), .echo_width(echo_width),
        .pulse(pulse), .busy(busy), .short_trig(short_trig), .timeout(timeout),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string name, input int waited);
        n_checks++;
        n_errors++;
        $display("FAIL %s: condition not reached after %0d cycles, required within budget", name, waited);
    endtask

    // Issue one trigger of n sampled-high edges; queue what the sensor must answer.
    task automatic fire(input int n, input logic [WIDTH-1:0] ew);
        int k;
        logic to;
        logic [WIDTH-1:0] w;
        echo_width = ew;
        triggerin = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_before_trig", busy, 0);
        triggerin = 1'b1;
        repeat (n) @(negedge clk);
        check("busy_during_trig", busy, 1);
        triggerin = 1'b0;
        k = cyc + 1;
        if (n < MIN_TRIG) begin
            exp_q.push_back({1'b1, 1'b0, 22'd0, 32'(k + 2)});
        end else begin
            to = (ew == 0) || (ew > MAX_ECHO);
            w = to ? WIDTH'(MAX_ECHO) : ew;
            exp_q.push_back({1'b0, to, w, 32'(k + 2 + BURST_CYCLES)});
        end
        repeat (3) @(negedge clk);
        echo_width = WIDTH'($urandom);
    endtask

    task automatic wait_pulse(input logic val, input int budget);
        int t = 0;
        while (pulse !== val && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (pulse !== val) bound_fail(val ? "wait_pulse_rise" : "wait_pulse_fall", t);
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        logic idle;
        idle = 1'b0;
        while (!idle && t < 3000) begin
            @(negedge clk);
            t++;
            idle = !busy && !pulse && (exp_q.size() == 0);
        end
        if (!idle) bound_fail(name, t);
    endtask

    // Monitor: compares every DUT event against the head of the expected queue.
    initial begin : monitor
        logic          prev_pulse;
        logic          prev_busy;
        int            rise_cyc;
        int            busy_fall_exp;
        logic [EW-1:0] e;
        prev_pulse = 1'b0;
        prev_busy = 1'b0;
        rise_cyc = 0;
        busy_fall_exp = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_pulse = 1'b0;
                prev_busy = 1'b0;
                continue;
            end
            if (short_trig) begin
                if (exp_q.size() == 0) begin
                    check("short_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("short_kind", 1, e[55]);
                    check("short_edge", cyc, e[31:0]);
                    busy_fall_exp = e[31:0];
                end
            end
            if (pulse && !prev_pulse) begin
                rise_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("rise_unexpected", 1, 0);
                end else begin
                    e = exp_q[0];
                    check("rise_kind", 0, e[55]);
                    check("rise_edge", cyc, e[31:0]);
                end
            end
            if (!pulse && prev_pulse) begin
                if (exp_q.size() == 0) begin
                    check("fall_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("echo_width", cyc - rise_cyc, e[53:32]);
                    check("timeout_at_fall", timeout, e[54]);
                end
                busy_fall_exp = cyc + HOLDOFF;
            end else if (timeout) begin
                check("timeout_spurious", timeout, 0);
            end
            if (!busy && prev_busy) check("busy_fall_edge", cyc, busy_fall_exp);
            prev_pulse = pulse;
            prev_busy = busy;
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int n;
        int sel;
        logic [WIDTH-1:0] ew;
        reset = 1'b1;
        triggerin = 1'b0;
        echo_width = '0;
        repeat (3) @(negedge clk);
        check("rst_pulse", pulse, 0);
        check("rst_busy", busy, 0);
        check("rst_short", short_trig, 0);
        check("rst_timeout", timeout, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_busy", busy, 0);

        fire(10, 300);
        wait_idle("nominal");
        fire(9, 300);
        wait_idle("short_trig");
        fire(10, 0);
        wait_idle("timeout_zero");
        fire(10, 5000);
        wait_idle("timeout_large");
        fire(10, WIDTH'(MAX_ECHO));
        wait_idle("max_exact");
        fire(10, WIDTH'(MAX_ECHO + 1));
        wait_idle("max_plus_one");
        fire(14, 1);
        wait_idle("width_one");

        // Retrigger during BURST, ECHO and HOLD, and echo_width change mid-echo.
        fire(10, 400);
        triggerin = 1'b1;
        repeat (3) @(negedge clk);
        triggerin = 1'b0;
        wait_pulse(1'b1, 100);
        repeat (10) @(negedge clk);
        triggerin = 1'b1;
        repeat (12) @(negedge clk);
        triggerin = 1'b0;
        echo_width = 50;
        wait_pulse(1'b0, 2000);
        triggerin = 1'b1;
        repeat (2) @(negedge clk);
        triggerin = 1'b0;
        wait_idle("retrigger");
        repeat (30) @(negedge clk);
        check("retrig_no_second", busy, 0);

        // Trigger held high across the end of HOLD must not start a measurement.
        fire(10, 200);
        wait_pulse(1'b1, 100);
        wait_pulse(1'b0, 2000);
        triggerin = 1'b1;
        wait_idle("held_idle");
        repeat (20) @(negedge clk);
        check("held_no_retrig", busy, 0);
        fire(10, 150);
        wait_idle("held_release");

        // Reset 50 cycles into the echo clears outputs without a clock edge.
        fire(10, 300);
        wait_pulse(1'b1, 100);
        repeat (50) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_pulse", pulse, 0);
        check("async_rst_busy", busy, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("after_rst_busy", busy, 0);
        fire(10, 300);
        wait_idle("after_reset");

        for (int i = 0; i < 10; i++) begin
            n = $urandom_range(8, 13);
            sel = $urandom_range(0, 4);
            case (sel)
                0: ew = '0;
                1: ew = WIDTH'($urandom_range(1, MAX_ECHO));
                2: ew = WIDTH'($urandom_range(MAX_ECHO + 1, 6000));
                3: ew = WIDTH'(MAX_ECHO);
                default: ew = WIDTH'($urandom_range(1, 40));
            endcase
            fire(n, ew);
            wait_idle("random");
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        repeat (20) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ultrasonic_echo_emulator.md
# ultrasonic_echo_emulator

- Behavioural responder for the ultrasonic ranging interface, standing in for the physical HC-SR04-style sensor.
- Accepts the trigger pulse driven by the ranging front end and validates its minimum width.
- After a fixed burst delay, returns an echo pulse whose width in fpgaclk cycles encodes a programmable distance.
- Closes the loop on-chip for bring-up and regression of the trigger/echo measurement path without hardware.

## Interface
- WIDTH, 22: width of echo-width input and internal counters.
- MIN_TRIG, 500: minimum valid trigger high time, cycles (10 µs at 50 MHz).
- BURST_CYCLES, 10000: delay from trigger fall to echo rise, cycles (40 kHz 8-cycle burst, 200 µs).
- MAX_ECHO, 1900000: no-object timeout echo width, cycles (38 ms); must be < 2^WIDTH.
- HOLDOFF, 500: dead time after echo fall before a new trigger is accepted, cycles.

Ports:
- fpgaclk, input, 1: sole clock, rising edge.
- reset, input, 1: asynchronous, active-high.
- triggerin, input, 1: trigger from the ranging front end; asynchronous to the FSM, passed through a 2-flop synchroniser.
- echo_width, input, WIDTH: requested echo high time, cycles; latched once per measurement.
- pulse, output, 1: echo to the front end; registered.
- busy, output, 1: high in every state except IDLE; registered.
- short_trig, output, 1: one-cycle strobe; trigger fell before MIN_TRIG.
- timeout, output, 1: one-cycle strobe at echo fall when the no-object width was used.

## Operation
- Reset: all outputs 0, synchroniser flops 0, state IDLE, counters 0.
- trig_s is the output of the 2-flop synchroniser; trig_d is trig_s delayed one cycle.
- IDLE: on trig_s & ~trig_d (rising edge) go to TRIG with cnt=1. A level held high on entry to IDLE is not a trigger.
- TRIG, trig_s high: cnt increments, saturating at MIN_TRIG.
- TRIG, trig_s low:
  - cnt >= MIN_TRIG: latch W, clear cnt, go to BURST.
  - cnt < MIN_TRIG: pulse short_trig, go to IDLE.
- W = MAX_ECHO when echo_width == 0 or echo_width > MAX_ECHO; this sets the internal timeout flag. Otherwise W = echo_width.
- BURST: count BURST_CYCLES cycles, then go to ECHO with pulse=1.
- ECHO: pulse stays high for exactly W cycles.
  - Then pulse=0 and go to HOLDOFF.
  - timeout pulses in the same cycle if the flag is set.
- HOLDOFF: count HOLDOFF cycles, ignoring triggerin, then go to IDLE.
- Trigger activity in BURST, ECHO or HOLDOFF is ignored.
- echo_width changes after the latch have no effect on the current measurement.
- Counters are WIDTH bits, compare-and-clear, never wrap.

## Timing
- Edge k is the first rising edge at which triggerin is sampled low after a valid high.
- State becomes BURST at edge k+2.
- pulse rises at edge k+2+BURST_CYCLES.
- pulse falls at edge k+2+BURST_CYCLES+W.
- Trigger width measured = number of edges at which triggerin was sampled high.
  - Exactly MIN_TRIG is valid.
  - MIN_TRIG-1 gives short_trig at edge k+2 and no echo.
- busy rises at the edge entering TRIG (2 edges after first high sample) and falls at the edge entering IDLE (HOLDOFF edges after pulse falls).
- Earliest accepted retrigger: a rising trig_s seen while in IDLE.
- Reset asserted mid-measurement (any state): pulse, busy and strobes go 0 immediately without waiting for a clock edge. State returns to IDLE; nothing resumes after release.

## Test plan
Bench parameters: MIN_TRIG=10, BURST_CYCLES=20, MAX_ECHO=1000, HOLDOFF=8.

- **Nominal echo:** triggerin high 10 cycles, echo_width=300.
  - pulse rises exactly 22 edges after the first low sample.
  - pulse stays high exactly 300 cycles.
  - short_trig=0, timeout=0.
- **Short trigger:** triggerin high 9 cycles.
  - short_trig high for 1 cycle at k+2.
  - pulse never rises; busy returns to 0.
- **No-object timeout:** echo_width=0, then separately echo_width=5000.
  - pulse high exactly 1000 cycles each time.
  - timeout pulses once at each fall.
- **Retrigger and latch:** after a valid trigger, pulse triggerin during BURST, ECHO and HOLDOFF, and change echo_width mid-ECHO.
  - Exactly one echo, with the originally latched width.
  - Next trigger is accepted only after busy falls.
- **Held trigger:** triggerin held high through the end of HOLDOFF.
  - No new measurement until triggerin goes low then high again.
- **Reset mid-ECHO:** assert reset 50 cycles into the echo.
  - pulse and busy go 0 asynchronously.
  - After release, a new 10-cycle trigger with echo_width=300 gives a correct 300-cycle echo.
